// File: rtl/div_if.sv
// Handshake and data bundle between the execute stage and the divider sequencer.
interface div_if #(parameter int WIDTH = 32);
   logic             ctrl_div;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic [WIDTH-1:0] data_remainder;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_div, data_operandA, data_operandB,
      input  data_result, data_remainder, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  ctrl_div, data_operandA, data_operandB,
      output data_result, data_remainder, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/div_sequencer.sv
// Multicycle signed restoring divider: abs pre-op, WIDTH shift/subtract steps,
// sign fix-up post-op, one-cycle ready pulse. A new start always aborts and restarts.
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic clock,
   input  logic reset,
   div_if.slave dif
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] dabs_q, dabs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_quo_q, sign_quo_d;
   logic             sign_rem_q, sign_rem_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             exception_q, exception_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   // Partial remainder is always below the divisor (at most 2^(WIDTH-1)), so the
   // shifted value fits in WIDTH+1 bits and the trial sign bit decides the step.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, dabs_q};
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      dabs_d      = dabs_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      sign_quo_d  = sign_quo_q;
      sign_rem_d  = sign_rem_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      exception_d = exception_q;
      ready_d     = 1'b0;
      busy_d      = busy_q;

      case (state_q)
         PRE: begin
            quo_d   = a_q[WIDTH-1] ? (~a_q + ONE) : a_q;
            dabs_d  = b_q[WIDTH-1] ? (~b_q + ONE) : b_q;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = ITER;
         end
         ITER: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
            end else begin
               rem_d = shifted[WIDTH-1:0];
            end
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = POST;
            end
         end
         POST: begin
            result_d    = sign_quo_q ? (~quo_q + ONE) : quo_q;
            remainder_d = sign_rem_q ? (~rem_q + ONE) : rem_q;
            busy_d      = 1'b0;
            ready_d     = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Start from any state overrides whatever the sequence was doing.
      if (dif.ctrl_div) begin
         a_d         = dif.data_operandA;
         b_d         = dif.data_operandB;
         sign_quo_d  = dif.data_operandA[WIDTH-1] ^ dif.data_operandB[WIDTH-1];
         sign_rem_d  = dif.data_operandA[WIDTH-1];
         if (dif.data_operandB == '0) begin
            result_d    = '0;
            remainder_d = '0;
            exception_d = 1'b1;
            ready_d     = 1'b1;
            busy_d      = 1'b0;
            state_d     = DONE;
         end else begin
            exception_d = 1'b0;
            ready_d     = 1'b0;
            busy_d      = 1'b1;
            state_d     = PRE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         dabs_q      <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         sign_quo_q  <= 1'b0;
         sign_rem_q  <= 1'b0;
         result_q    <= '0;
         remainder_q <= '0;
         exception_q <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         dabs_q      <= dabs_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
         sign_quo_q  <= sign_quo_d;
         sign_rem_q  <= sign_rem_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         exception_q <= exception_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
      end
   end

   assign dif.data_result    = result_q;
   assign dif.data_remainder = remainder_q;
   assign dif.data_exception = exception_q;
   assign dif.data_resultRDY = ready_q;
   assign dif.busy           = busy_q;
endmodule
